// File: rtl/led_blinker_pkg.sv
// Shared state encoding, default interval and timer sizing helpers for the LED blinker.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Half a second at 50 MHz.
  localparam int unsigned DEF_INTERVAL = 25_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Never returns less than 1 so a one-cycle interval still gets a legal vector.
  function automatic int unsigned tmr_width(input int unsigned on_c, input int unsigned off_c);
    int unsigned w;
    w = $clog2(max_u(on_c, off_c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_blinker_interval_timer.sv
// Up-counter that flags the final cycle of an interval; cleared on every phase change.
module interval_timer
  import led_blinker_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         last_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign last_o = en_i && (r_cnt == tc_i);

endmodule

// File: rtl/led_blinker.sv
// Blinks one LED a requested number of times on a start pulse, then pulses done for one cycle.
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_INTERVAL,
  parameter int unsigned OFF_CYCLES = DEF_INTERVAL,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             led_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned TMR_W = tmr_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TMR_W-1:0] ON_TC  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_TC = TMR_W'(OFF_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_led;
  logic               r_busy;
  logic               r_done;

  logic               w_last;
  logic               w_clr;
  logic               w_en;
  logic [TMR_W-1:0]   w_tc;

  // Every ON/OFF exit coincides with the last-cycle flag, so clearing on it restarts the next phase at 0.
  assign w_en  = (r_state != ST_IDLE);
  assign w_clr = (r_state == ST_IDLE) || w_last;
  assign w_tc  = (r_state == ST_ON) ? ON_TC : OFF_TC;

  interval_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_clr),
    .en_i   (w_en),
    .tc_i   (w_tc),
    .last_o (w_last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              r_remaining <= count_i;
              r_state     <= ST_ON;
              r_led       <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (w_last) begin
            r_state     <= ST_OFF;
            r_led       <= 1'b0;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        ST_OFF: begin
          if (w_last) begin
            if (r_remaining != '0) begin
              r_state <= ST_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led_o  = r_led;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker with ON=3, OFF=2, CNT_W=3.
module tb_led_blinker;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic [2:0] count_i;
  logic       led_o;
  logic       busy_o;
  logic       done_o;

  int checks;
  int failures;

  led_blinker #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .CNT_W      (3)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .count_i (count_i),
    .led_o   (led_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int cyc, input logic e_led, input logic e_busy,
                     input logic e_done);
    checks++;
    assert (led_o === e_led) else begin
      failures++;
      $error("FAIL %s cyc=%0d led observed=%b expected=%b", tag, cyc, led_o, e_led);
    end
    checks++;
    assert (busy_o === e_busy) else begin
      failures++;
      $error("FAIL %s cyc=%0d busy observed=%b expected=%b", tag, cyc, busy_o, e_busy);
    end
    checks++;
    assert (done_o === e_done) else begin
      failures++;
      $error("FAIL %s cyc=%0d done observed=%b expected=%b", tag, cyc, done_o, e_done);
    end
  endtask

  // Caller has already set start_i/count_i; first posedge is edge E. Expected strings are
  // written MSB-first, leftmost character = cycle E+1. Optionally injects a new start at cycle inj.
  task automatic run_seq(input string tag, input int n, input logic [31:0] el,
                         input logic [31:0] eb, input logic [31:0] ed,
                         input int inj, input logic [2:0] inj_cnt);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      chk(tag, i, el[n-i], eb[n-i], ed[n-i]);
      if (i == inj) begin
        start_i = 1'b1;
        count_i = inj_cnt;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b0;
    start_i  = 1'b0;
    count_i  = 3'd0;

    // Cold reset held with random start/count activity.
    #2;
    chk("rst_cold", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start_i = 1'($urandom_range(0, 1));
      count_i = 3'($urandom_range(0, 7));
      @(posedge clk_i);
      #1;
      chk("rst_hold", i, 1'b0, 1'b0, 1'b0);
    end
    start_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk_i);
    #1;
    chk("idle", 0, 1'b0, 1'b0, 1'b0);

    // count=2: two full blinks, done at E+11.
    start_i = 1'b1;
    count_i = 3'd2;
    run_seq("cnt2", 12, 32'b111001110000, 32'b111111111100, 32'b000000000010, 0, 3'd0);

    // count=0: immediate done, nothing lit.
    start_i = 1'b1;
    count_i = 3'd0;
    run_seq("cnt0", 3, 32'b000, 32'b000, 32'b100, 0, 3'd0);

    // count=1 with a start(7) at E+2 that must be ignored.
    start_i = 1'b1;
    count_i = 3'd1;
    run_seq("ignore", 9, 32'b111000000, 32'b111110000, 32'b000001000, 2, 3'd7);

    // Back-to-back: restart in the done cycle E+6.
    start_i = 1'b1;
    count_i = 3'd1;
    run_seq("b2b", 13, 32'b1110001110000, 32'b1111101111100, 32'b0000010000010, 6, 3'd1);

    // count=2 aborted by reset during the first ON phase.
    start_i = 1'b1;
    count_i = 3'd2;
    run_seq("abort_pre", 2, 32'b11, 32'b11, 32'b00, 0, 3'd0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("abort_async", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      start_i = 1'($urandom_range(0, 1));
      count_i = 3'($urandom_range(0, 7));
      @(posedge clk_i);
      #1;
      chk("abort_hold", i, 1'b0, 1'b0, 1'b0);
    end
    start_i = 1'b0;
    rst_i   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i);
      #1;
      chk("abort_quiet", i, 1'b0, 1'b0, 1'b0);
    end

    // After the abort a single blink behaves exactly as from cold reset.
    start_i = 1'b1;
    count_i = 3'd1;
    run_seq("post_rst", 7, 32'b1110000, 32'b1111100, 32'b0000010, 0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
